// File: rtl/axis2axi_in_pkg.sv
// Shared definitions for the AXI-Stream to AXI4 write DMA: FSM encodings,
// fixed AXI attribute values and 4 KiB boundary arithmetic.
package axis2axi_in_pkg;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CALC = 3'd1;
  localparam logic [2:0] S_ADDR = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  localparam logic [2:0] AXI_SIZE_4B = 3'd2;
  localparam logic [1:0] AXI_BURST_INCR = 2'd1;
  localparam logic [3:0] AXI_CACHE_VAL = 4'd2;
  localparam logic [2:0] AXI_PROT_VAL = 3'd2;

  localparam logic [12:0] BOUNDARY_4K = 13'h1000;

  // Number of 32-bit words between a word-aligned offset and the next 4 KiB page.
  function automatic logic [10:0] words_to_4k(input logic [11:0] offs);
    logic [12:0] bytes_left;
    bytes_left = BOUNDARY_4K - {1'b0, offs};
    return bytes_left[12:2];
  endfunction

endpackage

// File: rtl/axis2axi_in_buf.sv
// Synchronous FIFO between the stream input and the W channel. The level
// output lets the write FSM hold off AW until a whole burst is buffered.
module axis2axi_in_buf
  import axis2axi_in_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PTR_W  = 5
) (
  input  logic              clk_i,
  input  logic              cke_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [PTR_W:0]    level_o
);

  localparam int DEPTH = 2 ** PTR_W;
  localparam logic [PTR_W-1:0] PTR_ONE = 1;
  localparam logic [PTR_W:0]   LVL_ONE = 1;
  localparam logic [PTR_W:0]   LVL_FULL = (PTR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_q, rd_q;
  logic [PTR_W:0]    lvl_q, lvl_d;
  logic              full_q, empty_q;
  logic              do_push, do_pop;

  assign do_push = push_i & ~full_q;
  assign do_pop  = pop_i & ~empty_q;

  // Next fill level from the push/pop pair.
  always_comb begin
    lvl_d = lvl_q;
    unique case ({do_push, do_pop})
      2'b10:   lvl_d = lvl_q + LVL_ONE;
      2'b01:   lvl_d = lvl_q - LVL_ONE;
      default: lvl_d = lvl_q;
    endcase
  end

  // Pointers, level and the registered full/empty flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      lvl_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else if (cke_i) begin
      if (do_push) wr_q <= wr_q + PTR_ONE;
      if (do_pop)  rd_q <= rd_q + PTR_ONE;
      lvl_q   <= lvl_d;
      full_q  <= (lvl_d == LVL_FULL);
      empty_q <= (lvl_d == '0);
    end
  end

  // Storage array; contents need no reset since the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (cke_i && do_push) mem_q[wr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign level_o = lvl_q;

endmodule

// File: rtl/axis2axi_in.sv
// Stream-to-memory DMA writer: buffers AXI-Stream words and writes them out as
// AXI4 INCR bursts of at most 2**BURST_W beats that never cross 4 KiB.
module axis2axi_in
  import axis2axi_in_pkg::*;
#(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int AXI_LEN_W  = 8,
  parameter int AXI_ID_W   = 1,
  parameter int BURST_W    = 4
) (
  input  logic                    clk_i,
  input  logic                    cke_i,
  input  logic                    rst_i,
  input  logic [AXI_ADDR_W-1:0]   config_in_addr_i,
  input  logic [AXI_ADDR_W-1:0]   config_in_length_i,
  input  logic                    config_in_valid_i,
  output logic                    config_in_ready_o,
  input  logic [AXI_DATA_W-1:0]   axis_in_data_i,
  input  logic                    axis_in_valid_i,
  output logic                    axis_in_ready_o,
  output logic                    error_o,
  output logic [AXI_ID_W-1:0]     axi_awid_o,
  output logic [AXI_ADDR_W-1:0]   axi_awaddr_o,
  output logic [AXI_LEN_W-1:0]    axi_awlen_o,
  output logic [2:0]              axi_awsize_o,
  output logic [1:0]              axi_awburst_o,
  output logic                    axi_awlock_o,
  output logic [3:0]              axi_awcache_o,
  output logic [2:0]              axi_awprot_o,
  output logic [3:0]              axi_awqos_o,
  output logic                    axi_awvalid_o,
  input  logic                    axi_awready_i,
  output logic [AXI_DATA_W-1:0]   axi_wdata_o,
  output logic [AXI_DATA_W/8-1:0] axi_wstrb_o,
  output logic                    axi_wlast_o,
  output logic                    axi_wvalid_o,
  input  logic                    axi_wready_i,
  input  logic [AXI_ID_W-1:0]     axi_bid_i,
  input  logic [1:0]              axi_bresp_i,
  input  logic                    axi_bvalid_i,
  output logic                    axi_bready_o
);

  localparam logic [AXI_ADDR_W-1:0] MAX_BURST = AXI_ADDR_W'(2 ** BURST_W);
  localparam logic [AXI_ADDR_W-1:0] ADDR_ONE  = 1;
  localparam logic [BURST_W:0]      BSZ_ONE   = 1;
  localparam logic [AXI_LEN_W-1:0]  LEN_ONE   = 1;

  logic [2:0]            state_q, state_d;
  logic [AXI_ADDR_W-1:0] addr_q, remain_q, length_q, accepted_q;
  logic [AXI_LEN_W-1:0]  awlen_q, beat_q;
  logic [BURST_W:0]      bsize_q;
  logic                  error_q;

  logic [AXI_ADDR_W-1:0] w4k, sz;
  logic [BURST_W:0]      sz_b;
  logic                  cfg_hs, aw_hs, w_hs, b_hs, s_hs;
  logic                  fifo_full, fifo_empty;
  logic [BURST_W+1:0]    fifo_level;
  logic                  unused_ok;

  assign unused_ok = ^{axi_bid_i, sz[AXI_ADDR_W-1:BURST_W+1]};

  generate
    if (AXI_ADDR_W >= 13) begin : g_4k
      assign w4k = AXI_ADDR_W'(words_to_4k(addr_q[11:0]));
    end else begin : g_no_4k
      assign w4k = MAX_BURST;
    end
  endgenerate

  // Burst size = min(max burst, words remaining, words to the 4 KiB page end).
  always_comb begin
    sz = MAX_BURST;
    if (remain_q < sz) sz = remain_q;
    if (w4k < sz) sz = w4k;
    sz_b = sz[BURST_W:0];
  end

  assign cfg_hs = config_in_valid_i & config_in_ready_o;
  assign aw_hs  = axi_awvalid_o & axi_awready_i;
  assign w_hs   = axi_wvalid_o & axi_wready_i;
  assign b_hs   = axi_bvalid_i & axi_bready_o;
  assign s_hs   = axis_in_valid_i & axis_in_ready_o;

  axis2axi_in_buf #(
    .DATA_W (AXI_DATA_W),
    .PTR_W  (BURST_W + 1)
  ) u_buf (
    .clk_i   (clk_i),
    .cke_i   (cke_i),
    .rst_i   (rst_i),
    .push_i  (s_hs),
    .data_i  (axis_in_data_i),
    .pop_i   (w_hs),
    .data_o  (axi_wdata_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i)      state_q <= S_IDLE;
    else if (cke_i) state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (cfg_hs && config_in_length_i != '0) state_d = S_CALC;
      S_CALC: state_d = S_ADDR;
      S_ADDR: if (aw_hs) state_d = S_DATA;
      S_DATA: if (w_hs && axi_wlast_o) state_d = S_RESP;
      S_RESP: if (b_hs) state_d = (remain_q == '0) ? S_IDLE : S_CALC;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs; AW waits for a fully buffered burst so W never underflows.
  always_comb begin
    config_in_ready_o = (state_q == S_IDLE);
    axi_awvalid_o     = (state_q == S_ADDR) && (fifo_level >= {1'b0, bsize_q});
    axi_wvalid_o      = (state_q == S_DATA) && !fifo_empty;
    axi_wlast_o       = (state_q == S_DATA) && (beat_q == awlen_q);
    axi_bready_o      = (state_q == S_RESP);
    axis_in_ready_o   = (state_q != S_IDLE) && (accepted_q < length_q) && !fifo_full;
  end

  // Job address/length bookkeeping, burst sizing, beat count and error flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q     <= '0;
      remain_q   <= '0;
      length_q   <= '0;
      accepted_q <= '0;
      awlen_q    <= '0;
      bsize_q    <= '0;
      beat_q     <= '0;
      error_q    <= 1'b0;
    end else if (cke_i) begin
      if (cfg_hs) begin
        addr_q     <= config_in_addr_i;
        remain_q   <= config_in_length_i;
        length_q   <= config_in_length_i;
        accepted_q <= '0;
        error_q    <= 1'b0;
      end
      if (s_hs) accepted_q <= accepted_q + ADDR_ONE;
      if (state_q == S_CALC) begin
        bsize_q  <= sz_b;
        awlen_q  <= AXI_LEN_W'(sz_b - BSZ_ONE);
        remain_q <= remain_q - sz;
      end
      if (aw_hs) beat_q <= '0;
      else if (w_hs) beat_q <= beat_q + LEN_ONE;
      if (b_hs) begin
        error_q <= error_q | (axi_bresp_i != 2'b00);
        addr_q  <= addr_q + AXI_ADDR_W'({bsize_q, 2'b00});
      end
    end
  end

  assign error_o       = error_q;
  assign axi_awaddr_o  = addr_q;
  assign axi_awlen_o   = awlen_q;
  assign axi_awid_o    = '0;
  assign axi_awsize_o  = AXI_SIZE_4B;
  assign axi_awburst_o = AXI_BURST_INCR;
  assign axi_awlock_o  = 1'b0;
  assign axi_awcache_o = AXI_CACHE_VAL;
  assign axi_awprot_o  = AXI_PROT_VAL;
  assign axi_awqos_o   = 4'd0;
  assign axi_wstrb_o   = '1;

endmodule

// File: tb/tb_axis2axi_in.sv
// Directed bench for axis2axi_in: a table of DMA jobs with expected bursts,
// a cycle-level AXI slave / stream source model, and hand-written reset cases.
module tb_axis2axi_in;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 8;
  localparam int IW = 1;
  localparam int BW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          cke_i, rst_i;
  logic [AW-1:0] config_in_addr_i, config_in_length_i;
  logic          config_in_valid_i, config_in_ready_o;
  logic [DW-1:0] axis_in_data_i;
  logic          axis_in_valid_i, axis_in_ready_o;
  logic          error_o;
  logic [IW-1:0] axi_awid_o;
  logic [AW-1:0] axi_awaddr_o;
  logic [LW-1:0] axi_awlen_o;
  logic [2:0]    axi_awsize_o;
  logic [1:0]    axi_awburst_o;
  logic          axi_awlock_o;
  logic [3:0]    axi_awcache_o;
  logic [2:0]    axi_awprot_o;
  logic [3:0]    axi_awqos_o;
  logic          axi_awvalid_o, axi_awready_i;
  logic [DW-1:0] axi_wdata_o;
  logic [DW/8-1:0] axi_wstrb_o;
  logic          axi_wlast_o, axi_wvalid_o, axi_wready_i;
  logic [IW-1:0] axi_bid_i;
  logic [1:0]    axi_bresp_i;
  logic          axi_bvalid_i, axi_bready_o;

  axis2axi_in #(
    .AXI_ADDR_W(AW), .AXI_DATA_W(DW), .AXI_LEN_W(LW), .AXI_ID_W(IW), .BURST_W(BW)
  ) dut (
    .clk_i(clk), .cke_i(cke_i), .rst_i(rst_i),
    .config_in_addr_i(config_in_addr_i), .config_in_length_i(config_in_length_i),
    .config_in_valid_i(config_in_valid_i), .config_in_ready_o(config_in_ready_o),
    .axis_in_data_i(axis_in_data_i), .axis_in_valid_i(axis_in_valid_i),
    .axis_in_ready_o(axis_in_ready_o), .error_o(error_o),
    .axi_awid_o(axi_awid_o), .axi_awaddr_o(axi_awaddr_o), .axi_awlen_o(axi_awlen_o),
    .axi_awsize_o(axi_awsize_o), .axi_awburst_o(axi_awburst_o), .axi_awlock_o(axi_awlock_o),
    .axi_awcache_o(axi_awcache_o), .axi_awprot_o(axi_awprot_o), .axi_awqos_o(axi_awqos_o),
    .axi_awvalid_o(axi_awvalid_o), .axi_awready_i(axi_awready_i),
    .axi_wdata_o(axi_wdata_o), .axi_wstrb_o(axi_wstrb_o), .axi_wlast_o(axi_wlast_o),
    .axi_wvalid_o(axi_wvalid_o), .axi_wready_i(axi_wready_i),
    .axi_bid_i(axi_bid_i), .axi_bresp_i(axi_bresp_i),
    .axi_bvalid_i(axi_bvalid_i), .axi_bready_o(axi_bready_o)
  );

  typedef struct {
    logic [31:0]      addr;
    logic [31:0]      len;
    int               extra;
    bit               rnd;
    int               nb;
    logic [3:0][31:0] aw_addr;
    logic [3:0][7:0]  aw_len;
    logic [3:0][1:0]  bresp;
    bit               exp_err;
  } vec_t;

  vec_t vecs[9];
  vec_t cur;

  int n_chk = 0;
  int n_fail = 0;

  bit rnd_mode;
  int s_cnt, s_limit, job_start, w_total;
  bit s_pend, cfg_pend, b_hold, w_active, aw_wait;
  int nb_aw, nb_b, b_pend, beat;
  logic [31:0] w_addr, aw_prev_addr;
  logic [7:0]  w_len;
  logic [31:0] mem [logic [31:0]];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] a, input int len, input int extra,
                              input bit rnd, input int nb,
                              input logic [31:0] a0, input logic [7:0] l0,
                              input logic [31:0] a1, input logic [7:0] l1,
                              input logic [31:0] a2, input logic [7:0] l2,
                              input logic [1:0] br1, input bit err);
    vec_t v;
    v.addr = a; v.len = 32'(len); v.extra = extra; v.rnd = rnd; v.nb = nb;
    v.aw_addr = '0; v.aw_len = '0; v.bresp = '0;
    v.aw_addr[0] = a0; v.aw_len[0] = l0;
    v.aw_addr[1] = a1; v.aw_len[1] = l1;
    v.aw_addr[2] = a2; v.aw_len[2] = l2;
    v.bresp[1] = br1;
    v.exp_err = err;
    return v;
  endfunction

  // One clock: drive inputs after the falling edge, then observe handshakes
  // that the next rising edge will complete.
  task automatic cycle();
    int lvl;
    @(negedge clk);
    axi_awready_i = rnd_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
    axi_wready_i  = rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (!s_pend && s_cnt < s_limit && (!rnd_mode || $urandom_range(0, 2) != 0)) s_pend = 1;
    axis_in_valid_i = s_pend;
    axis_in_data_i  = 32'(s_cnt);
    if (!b_hold && b_pend > 0 && (!rnd_mode || $urandom_range(0, 1) == 1)) b_hold = 1;
    axi_bvalid_i = b_hold;
    axi_bresp_i  = (nb_b < 4) ? cur.bresp[nb_b] : 2'b00;
    config_in_valid_i = cfg_pend;
    #1;
    if (aw_wait) begin
      chk("awvalid_hold", axi_awvalid_o, 1);
      chk("awaddr_stable", axi_awaddr_o, aw_prev_addr);
    end
    aw_wait = axi_awvalid_o && !axi_awready_i;
    aw_prev_addr = axi_awaddr_o;
    if (w_active) begin
      chk("wvalid_in_burst", axi_wvalid_o, 1);
      if (axi_wvalid_o && axi_wready_i) begin
        mem[w_addr + 32'(beat) * 4] = axi_wdata_o;
        chk("wlast", axi_wlast_o, (beat == int'(w_len)));
        w_total++;
        if (beat == int'(w_len)) begin
          w_active = 0;
          b_pend++;
        end
        beat++;
      end
    end else begin
      chk("wvalid_outside_burst", axi_wvalid_o, 0);
    end
    if (axi_awvalid_o && axi_awready_i) begin
      lvl = (s_cnt - job_start) - w_total;
      chk("aw_burst_buffered", (lvl >= int'(axi_awlen_o) + 1), 1);
      if (nb_aw < cur.nb && nb_aw < 4) begin
        chk("awaddr", axi_awaddr_o, cur.aw_addr[nb_aw]);
        chk("awlen", axi_awlen_o, cur.aw_len[nb_aw]);
      end
      w_addr = axi_awaddr_o; w_len = axi_awlen_o; beat = 0; w_active = 1;
      nb_aw++;
    end
    if (config_in_valid_i && config_in_ready_o) cfg_pend = 0;
    if (axis_in_valid_i && axis_in_ready_o) begin
      s_cnt++;
      s_pend = 0;
    end
    if (axi_bvalid_i && axi_bready_o) begin
      b_pend--; nb_b++; b_hold = 0;
    end
  endtask

  task automatic run_job(input vec_t v);
    int n;
    logic [31:0] a;
    cur = v; rnd_mode = v.rnd; mem.delete();
    nb_aw = 0; nb_b = 0; w_total = 0;
    job_start = s_cnt;
    s_limit = s_cnt + int'(v.len) + v.extra;
    config_in_addr_i = v.addr; config_in_length_i = v.len; cfg_pend = 1;
    n = 0;
    while (cfg_pend && n < 100) begin cycle(); n++; end
    chk("cfg_handshake", cfg_pend, 0);
    if (v.len == 0) begin
      repeat (6) begin
        cycle();
        chk("len0_cfg_ready", config_in_ready_o, 1);
        chk("len0_axis_ready", axis_in_ready_o, 0);
      end
    end else begin
      n = 0;
      do begin cycle(); n++; end while (!config_in_ready_o && n < 3000);
      chk("job_done_in_time", config_in_ready_o, 1);
    end
    chk("aw_count", nb_aw, v.nb);
    chk("b_count", nb_b, v.nb);
    chk("accepted_words", s_cnt - job_start, v.len);
    for (int i = 0; i < int'(v.len); i++) begin
      a = v.addr + 32'(i) * 4;
      chk("mem_word", mem.exists(a) ? mem[a] : 32'hxxxxxxxx, 32'(job_start + i));
    end
    chk("error_o", error_o, v.exp_err);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = mk(32'h0000_0000, 16, 0, 0, 1, 32'h0000, 15, 32'h0, 0, 32'h0, 0, 2'd0, 0);
    vecs[1] = mk(32'h0000_0FF8, 8, 0, 0, 2, 32'h0FF8, 1, 32'h1000, 5, 32'h0, 0, 2'd0, 0);
    vecs[2] = mk(32'h0000_2000, 37, 0, 1, 3, 32'h2000, 15, 32'h2040, 15, 32'h2080, 4, 2'd0, 0);
    vecs[3] = mk(32'h0000_3000, 20, 0, 1, 2, 32'h3000, 15, 32'h3040, 3, 32'h0, 0, 2'd2, 1);
    vecs[4] = mk(32'h0000_4000, 0, 2, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 2'd0, 0);
    vecs[5] = mk(32'h0000_5FFC, 3, 2, 0, 2, 32'h5FFC, 0, 32'h6000, 1, 32'h0, 0, 2'd0, 0);
    vecs[6] = mk(32'hFFFF_FFF8, 4, 0, 1, 2, 32'hFFFF_FFF8, 1, 32'h0, 1, 32'h0, 0, 2'd0, 0);
    vecs[7] = mk(32'h0000_9000, 4, 0, 0, 1, 32'h9000, 3, 32'h0, 0, 32'h0, 0, 2'd0, 0);
    vecs[8] = mk(32'h0000_8000, 16, 0, 0, 1, 32'h8000, 15, 32'h0, 0, 32'h0, 0, 2'd0, 0);

    cur = vecs[0];
    rnd_mode = 0; s_cnt = 0; s_limit = 0; job_start = 0; w_total = 0;
    s_pend = 0; cfg_pend = 0; b_hold = 0; w_active = 0; aw_wait = 0;
    nb_aw = 0; nb_b = 0; b_pend = 0; beat = 0; w_addr = '0; w_len = '0; aw_prev_addr = '0;
    cke_i = 1; rst_i = 1;
    config_in_addr_i = '0; config_in_length_i = '0; config_in_valid_i = 0;
    axis_in_data_i = '0; axis_in_valid_i = 0;
    axi_awready_i = 0; axi_wready_i = 0; axi_bid_i = '0; axi_bresp_i = '0; axi_bvalid_i = 0;

    // Power-on reset values.
    repeat (3) cycle();
    chk("rst_cfg_ready", config_in_ready_o, 1);
    chk("rst_awvalid", axi_awvalid_o, 0);
    chk("rst_wvalid", axi_wvalid_o, 0);
    chk("rst_bready", axi_bready_o, 0);
    chk("rst_wlast", axi_wlast_o, 0);
    chk("rst_axis_ready", axis_in_ready_o, 0);
    chk("rst_error", error_o, 0);
    chk("rst_awaddr", axi_awaddr_o, 0);
    chk("rst_awlen", axi_awlen_o, 0);
    chk("rst_fifo_level", dut.u_buf.level_o, 0);
    rst_i = 0;
    chk("awsize", axi_awsize_o, 2);
    chk("awburst", axi_awburst_o, 1);
    chk("awcache", axi_awcache_o, 2);
    chk("awprot", axi_awprot_o, 2);
    chk("wstrb", axi_wstrb_o, 4'hF);

    for (int k = 0; k < 7; k++) run_job(vecs[k]);

    // Reset in the middle of a DATA phase, then a fresh job.
    cur = vecs[8]; rnd_mode = 0; mem.delete();
    nb_aw = 0; nb_b = 0; w_total = 0; job_start = s_cnt;
    s_limit = s_cnt + 16;
    config_in_addr_i = vecs[8].addr; config_in_length_i = vecs[8].len; cfg_pend = 1;
    n = 0;
    while (!(w_active && beat >= 3) && n < 200) begin cycle(); n++; end
    chk("reached_data_phase", (w_active && beat >= 3), 1);
    rst_i = 1;
    w_active = 0; b_pend = 0; b_hold = 0; cfg_pend = 0; aw_wait = 0;
    cycle();
    chk("midrst_awvalid", axi_awvalid_o, 0);
    chk("midrst_wvalid", axi_wvalid_o, 0);
    chk("midrst_cfg_ready", config_in_ready_o, 1);
    chk("midrst_axis_ready", axis_in_ready_o, 0);
    chk("midrst_bready", axi_bready_o, 0);
    chk("midrst_fifo_level", dut.u_buf.level_o, 0);
    rst_i = 0;
    run_job(vecs[7]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
